lfsr_word_ctrl: RTL and testbench

//  Sequencer around a 4-bit Fibonacci LFSR (x^4+x^3+1).
//  - Loads a seed into the LFSR.
//  - On request, steps the LFSR WORD_W times and packs the serial q bits into one parallel word.
//  - Delivers the word on a valid/ready port.

---
 rtl/lfsr_ctrl_pkg.sv | 28 ++
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_word_ctrl.sv | 150 +++++++++++++++
 tb/tb_lfsr_word_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR word sequencer: state encoding, LFSR
// geometry, feedback taps and the seed lock-up guard.
package lfsr_ctrl_pkg;

    localparam int             LFSR_W     = 4;
    // Taps for x^4+x^3+1: feedback is s[3]^s[2].
    localparam logic [LFSR_W-1:0] TAP        = 4'b1100;
    // All-zero is the LFSR's dead state; it is swapped for this value.
    localparam logic [LFSR_W-1:0] LOCKUP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // One Fibonacci step: shift left, feedback into the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP)};
    endfunction

    // Seed sanitiser: never let the register hold all zeros.
    function automatic logic [LFSR_W-1:0] seed_guard(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LOCKUP_SUB : s;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// 4-bit Fibonacci LFSR register (x^4+x^3+1) with synchronous load and step
// enable. q is the current MSB; load has priority over en.
module lfsr_core
    import lfsr_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic              q
);

    logic [LFSR_W-1:0] s_q, s_d;

    // Next state: load a seed, step, or hold.
    always_comb begin
        s_d = s_q;
        if (load)
            s_d = seed;
        else if (en)
            s_d = lfsr_step(s_q);
    end

    // State register, async active-low reset to the default seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            s_q <= DEFAULT_SEED;
        else
            s_q <= s_d;
    end

    assign q = s_q[LFSR_W-1];

endmodule

// File: rtl/lfsr_word_ctrl.sv
// LFSR word sequencer: loads seeds, shifts WORD_W serial LFSR bits into a
// parallel word (first bit ends up in the MSB) and offers it on a
// valid/ready port. The LFSR only advances while a word is being built.
// Build option LFSR_CTRL_SEED_PEND_EN: when defined, a seed written while
// busy is kept and loaded at the next IDLE ahead of any request; when
// undefined, such a seed is discarded and seed_drop pulses for one cycle.
module lfsr_word_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int                WORD_W       = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              seed_wr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifndef LFSR_CTRL_SEED_PEND_EN
    ,
    output logic              seed_drop
`endif
);

    localparam int                CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic              lfsr_load, lfsr_en, lfsr_q;
    logic              seed_pend;

`ifdef LFSR_CTRL_SEED_PEND_EN
    logic pend_q, pend_d;
    assign seed_pend = pend_q;
`else
    logic drop_q, drop_d;
    assign seed_pend = 1'b0;
`endif

    lfsr_core #(
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .seed (seed_q),
        .q    (lfsr_q)
    );

    // FSM next state, bit counter, word shifter and seed capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        seed_d    = seed_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        req_ready = 1'b0;
`ifdef LFSR_CTRL_SEED_PEND_EN
        pend_d    = pend_q;
        // Busy-time seed writes are parked; the latest one wins.
        if (seed_wr && state_q != ST_IDLE) begin
            seed_d = seed_guard(seed_in);
            pend_d = 1'b1;
        end
`else
        drop_d    = seed_wr && (state_q != ST_IDLE);
`endif
        case (state_q)
            ST_IDLE: begin
                // A seed (fresh or parked) always beats a request.
                req_ready = !seed_wr && !seed_pend;
                if (seed_wr || seed_pend) begin
                    if (seed_wr)
                        seed_d = seed_guard(seed_in);
                    state_d = ST_LOAD;
                end else if (req_valid) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                lfsr_load = 1'b1;
                state_d   = ST_IDLE;
`ifdef LFSR_CTRL_SEED_PEND_EN
                // A write landing during LOAD stays parked for another pass.
                if (!seed_wr)
                    pend_d = 1'b0;
`endif
            end
            ST_SHIFT: begin
                data_d = {data_q[WORD_W-2:0], lfsr_q};
                cnt_d  = cnt_q + 1'b1;
                // The final bit is sampled without advancing, so the next
                // word opens on the state that closed this one
                // (seed 4'b0011 gives 8'h35 then 8'hF1).
                if (cnt_q == LAST)
                    state_d = ST_HOLD;
                else
                    lfsr_en = 1'b1;
            end
            ST_HOLD: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            seed_q  <= DEFAULT_SEED;
`ifdef LFSR_CTRL_SEED_PEND_EN
            pend_q  <= 1'b0;
`else
            drop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            seed_q  <= seed_d;
`ifdef LFSR_CTRL_SEED_PEND_EN
            pend_q  <= pend_d;
`else
            drop_q  <= drop_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
`ifndef LFSR_CTRL_SEED_PEND_EN
    assign seed_drop = drop_q;
`endif

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Self-checking bench for lfsr_word_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a stream-level model.
module tb_lfsr_word_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   seed_in = 4'd0;
    logic         seed_wr = 1'b0;
    logic         req_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         req_ready, out_valid, busy;
    logic [W-1:0] out_data;
`ifndef LFSR_CTRL_SEED_PEND_EN
    logic         seed_drop;
`endif

    lfsr_word_ctrl #(.WORD_W(W), .DEFAULT_SEED(4'b0011)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_in   (seed_in),
        .seed_wr   (seed_wr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifndef LFSR_CTRL_SEED_PEND_EN
        ,
        .seed_drop (seed_drop)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int m_s;   // model LFSR state as an integer 1..15

    typedef struct {
        logic [3:0]   seed;
        logic [W-1:0] word;
        logic [3:0]   state_after;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The word is W consecutive MSBs of the LFSR sequence starting at s0;
    // only W-1 steps are taken, so s_end is the state that gave the last bit.
    function automatic logic [W-1:0] model_word(input int s0, output int s_end);
        int s;
        logic [W-1:0] w;
        s = s0;
        w = '0;
        for (int i = 0; i < W; i++) begin
            w = {w[W-2:0], 1'(s / 8)};
            if (i != W - 1)
                s = ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
        end
        s_end = s;
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_seed(input logic [3:0] s);
        seed_in = s;
        seed_wr = 1'b1;
        cyc();
        seed_wr = 1'b0;
        cyc();
        m_s = (s == 4'd0) ? 1 : int'(s);
    endtask

    // Wait for out_valid with a cycle bound; returns cycles waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            cyc();
            lat++;
        end
    endtask

    task automatic get_word(input int rd, output logic [W-1:0] word, output int lat,
                            output logic [W-1:0] exp);
        int t, nxt;
        exp = model_word(m_s, nxt);
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            cyc();
            t++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        wait_valid(lat);
        word = out_data;
        repeat (rd) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("data_kept", 32'(out_data), 32'(exp));
        m_s = nxt;
    endtask

    initial begin
        vec_t         vec [5];
        logic [W-1:0] w, e, d0;
        logic [3:0]   s0;
        int           lat, bad, nxt;

        vec[0] = '{seed: 4'b0011, word: 8'h35, state_after: 4'b1111};
        vec[1] = '{seed: 4'b0000, word: 8'h13, state_after: 4'b1010};
        vec[2] = '{seed: 4'b0001, word: 8'h13, state_after: 4'b1010};
        vec[3] = '{seed: 4'b1111, word: 8'hF1, state_after: 4'b1001};
        vec[4] = '{seed: 4'b1000, word: 8'h89, state_after: 4'b1101};

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_lfsr", 32'(dut.u_core.s_q), 32'h3);
`ifndef LFSR_CTRL_SEED_PEND_EN
        check("rst_seed_drop", 32'(seed_drop), 32'd0);
`endif
        cyc();
        rst = 1'b1;
        cyc();
        m_s = 3;

        // Two words straight from the reset seed
        get_word(0, w, lat, e);
        check("t1_word", 32'(w), 32'h35);
        check("t1_latency", 32'(lat), 32'(W));
        check("t1_lfsr", 32'(dut.u_core.s_q), 32'hF);
        get_word(1, w, lat, e);
        check("t2_word", 32'(w), 32'hF1);

        // Seed table
        foreach (vec[i]) begin
            write_seed(vec[i].seed);
            get_word(i % 3, w, lat, e);
            check("vec_word", 32'(w), 32'(vec[i].word));
            check("vec_latency", 32'(lat), 32'(W));
            check("vec_lfsr", 32'(dut.u_core.s_q), 32'(vec[i].state_after));
        end

        // Back-pressure: HOLD for 20 cycles with a request pending
        write_seed(4'b0011);
        req_valid = 1'b1;
        cyc();
        wait_valid(lat);
        d0 = out_data;
        s0 = dut.u_core.s_q;
        bad = 0;
        repeat (20) begin
            cyc();
            if (out_valid !== 1'b1 || out_data !== d0 || req_ready !== 1'b0 ||
                dut.u_core.s_q !== s0)
                bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        check("hold_word", 32'(d0), 32'h35);
        req_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("hold_release", 32'(out_valid), 32'd0);
        m_s = 15;

        // Seed and request in the same IDLE cycle: seed first
        seed_in = 4'b1000;
        seed_wr = 1'b1;
        req_valid = 1'b1;
        #1;
        check("coll_ready_low", 32'(req_ready), 32'd0);
        cyc();
        seed_wr = 1'b0;
        check("coll_load_ready", 32'(req_ready), 32'd0);
        cyc();
        check("coll_ready_2cyc", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        check("coll_accepted", 32'(busy), 32'd1);
        wait_valid(lat);
        check("coll_word", 32'(out_data), 32'h89);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        m_s = 13;

        // Reset while shifting (cnt==4)
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (4) cyc();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_lfsr", 32'(dut.u_core.s_q), 32'h3);
        cyc();
        rst = 1'b1;
        m_s = 3;
        get_word(0, w, lat, e);
        check("mid_rst_word", 32'(w), 32'h35);

        // Seed write during SHIFT
        e = model_word(m_s, nxt);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        seed_in = 4'b0101;
        seed_wr = 1'b1;
        cyc();
        seed_wr = 1'b0;
`ifndef LFSR_CTRL_SEED_PEND_EN
        check("drop_pulse", 32'(seed_drop), 32'd1);
        cyc();
        check("drop_clear", 32'(seed_drop), 32'd0);
`endif
        wait_valid(lat);
        check("busy_seed_word", 32'(out_data), 32'(e));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
`ifdef LFSR_CTRL_SEED_PEND_EN
        m_s = 5;
`else
        m_s = nxt;
`endif
        get_word(0, w, lat, e);
        check("after_busy_seed", 32'(w), 32'(e));

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_seed(4'($urandom_range(0, 15)));
            end else begin
                get_word(int'($urandom_range(0, 3)), w, lat, e);
                check("rand_word", 32'(w), 32'(e));
                check("rand_latency", 32'(lat), 32'(W));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
